// File: rtl/pong_if.sv
// pong_if: groups the tile-coordinate, button and game-status signals that run
// between the button/VGA side and the pong engine.
//
// Signals:
//   i_Row, i_Col          tile coordinates of the pixel being drawn
//   i_P1_Up/Down,
//   i_P2_Up/Down          debounced buttons, active high
//   i_Start               start/restart request (level; edge found inside engine)
//   o_Draw                registered draw flag for (i_Row, i_Col)
//   o_P1_Score/o_P2_Score current scores
//   o_State               0=IDLE 1=PLAY 2=SCORED 3=GAME_OVER
//   o_Game_Over           high while in GAME_OVER
//
// Handshake: there is no valid/ready pair on this bus. Every input is sampled
// on every rising clock edge and every output is a registered level that is
// valid in every cycle; a consumer may read any output at any time.
//
// Modports: master drives the inputs (VGA/button side or bench), slave is the
// engine.
interface pong_if #(
  parameter int COORD_WIDTH = 6,
  parameter int SCORE_WIDTH = 4
);
  logic [COORD_WIDTH-1:0] i_Row;
  logic [COORD_WIDTH-1:0] i_Col;
  logic                   i_P1_Up;
  logic                   i_P1_Down;
  logic                   i_P2_Up;
  logic                   i_P2_Down;
  logic                   i_Start;
  logic                   o_Draw;
  logic [SCORE_WIDTH-1:0] o_P1_Score;
  logic [SCORE_WIDTH-1:0] o_P2_Score;
  logic [1:0]             o_State;
  logic                   o_Game_Over;

  modport master (
    output i_Row, i_Col, i_P1_Up, i_P1_Down, i_P2_Up, i_P2_Down, i_Start,
    input  o_Draw, o_P1_Score, o_P2_Score, o_State, o_Game_Over
  );

  modport slave (
    input  i_Row, i_Col, i_P1_Up, i_P1_Down, i_P2_Up, i_P2_Down, i_Start,
    output o_Draw, o_P1_Score, o_P2_Score, o_State, o_Game_Over
  );
endinterface

// File: rtl/pong_engine.sv
// pong_engine: Pong game core. Moves two paddles and a ball on a tile grid,
// keeps per-player scores, and sequences serve / point / game-over.
//
// Ports:
//   i_Clk    system clock, rising edge
//   i_Rst_n  asynchronous active-low reset
//   bus      pong_if.slave: tile coordinates, buttons and start request in;
//            draw flag, scores, state and game-over flag out (all registered)
//
// The FSM state is visible on bus.o_State.
module pong_engine #(
  parameter int GAME_WIDTH    = 40,
  parameter int GAME_HEIGHT   = 30,
  parameter int COORD_WIDTH   = 6,
  parameter int PADDLE_HEIGHT = 6,
  parameter int BALL_SPEED    = 1250000,
  parameter int PADDLE_SPEED  = 1250000,
  parameter int POINT_HOLD    = 16,
  parameter int SCORE_WIDTH   = 4,
  parameter int SCORE_LIMIT   = 9
) (
  input logic   i_Clk,
  input logic   i_Rst_n,
  pong_if.slave bus
);

  localparam int CW  = COORD_WIDTH;
  localparam int SW  = SCORE_WIDTH;
  localparam int BCW = $clog2(BALL_SPEED + 1);
  localparam int PCW = $clog2(PADDLE_SPEED + 1);
  localparam int HCW = $clog2(POINT_HOLD + 1);

  localparam logic [CW-1:0] C_ZERO    = '0;
  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [CW-1:0] C_TWO     = CW'(2);
  localparam logic [CW-1:0] C_X_MID   = CW'(GAME_WIDTH / 2);
  localparam logic [CW-1:0] C_Y_MID   = CW'(GAME_HEIGHT / 2);
  localparam logic [CW-1:0] C_X_MAX   = CW'(GAME_WIDTH - 1);
  localparam logic [CW-1:0] C_X_RGT   = CW'(GAME_WIDTH - 2);
  localparam logic [CW-1:0] C_Y_MAX   = CW'(GAME_HEIGHT - 1);
  localparam logic [CW-1:0] C_Y_BOT   = CW'(GAME_HEIGHT - 2);
  localparam logic [CW-1:0] C_TOP_MAX = CW'(GAME_HEIGHT - PADDLE_HEIGHT);
  localparam logic [CW-1:0] C_TOP_RST = CW'((GAME_HEIGHT - PADDLE_HEIGHT) / 2);
  localparam logic [CW-1:0] C_PAD_EXT = CW'(PADDLE_HEIGHT - 1);

  localparam logic [SW-1:0]  C_LIMIT     = SW'(SCORE_LIMIT);
  localparam logic [SW-1:0]  C_SONE      = SW'(1);
  localparam logic [BCW-1:0] C_BALL_LAST = BCW'(BALL_SPEED - 1);
  localparam logic [BCW-1:0] C_BONE      = BCW'(1);
  localparam logic [PCW-1:0] C_PAD_LAST  = PCW'(PADDLE_SPEED - 1);
  localparam logic [PCW-1:0] C_PONE      = PCW'(1);
  localparam logic [HCW-1:0] C_HOLD_LAST = HCW'(POINT_HOLD - 1);
  localparam logic [HCW-1:0] C_HONE      = HCW'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PLAY      = 2'd1,
    S_SCORED    = 2'd2,
    S_GAME_OVER = 2'd3
  } state_t;

  // Registers
  state_t          r_state;
  logic [CW-1:0]   r_ball_x, r_ball_y;
  logic            r_dx_neg, r_dy_neg;     // 1 = moving toward 0
  logic [CW-1:0]   r_p1_top, r_p2_top;
  logic [SW-1:0]   r_p1_score, r_p2_score;
  logic [BCW-1:0]  r_ball_cnt;
  logic [PCW-1:0]  r_pad_cnt;
  logic [HCW-1:0]  r_hold_cnt;
  logic            r_start_sync, r_start_d;
  logic            r_draw;
  logic            r_game_over;

  // Next-state wires
  state_t          w_next_state;
  logic [CW-1:0]   w_ball_x_nxt, w_ball_y_nxt;
  logic            w_dx_neg_nxt, w_dy_neg_nxt;
  logic [SW-1:0]   w_p1_score_nxt, w_p2_score_nxt;
  logic [BCW-1:0]  w_ball_cnt_nxt;
  logic [HCW-1:0]  w_hold_nxt;
  logic            w_ball_tick, w_pad_tick, w_start_edge;
  logic            w_ball_in_p1, w_ball_in_p2;
  logic            w_draw;

  function automatic logic f_in_span(input logic [CW-1:0] row,
                                     input logic [CW-1:0] top);
    f_in_span = (row >= top) && (row <= top + C_PAD_EXT);
  endfunction

  // Up only moves up, down only moves down; both or neither hold still.
  function automatic logic [CW-1:0] f_paddle_next(input logic [CW-1:0] top,
                                                  input logic up,
                                                  input logic down);
    f_paddle_next = top;
    if (up && !down && top != C_ZERO)
      f_paddle_next = top - C_ONE;
    else if (down && !up && top != C_TOP_MAX)
      f_paddle_next = top + C_ONE;
  endfunction

  assign w_ball_tick  = (r_ball_cnt == C_BALL_LAST);
  assign w_pad_tick   = (r_pad_cnt == C_PAD_LAST);
  // i_Start is registered once, so the edge shows up one cycle after the
  // first sample of 1 and the state moves at the end of that cycle.
  assign w_start_edge = r_start_sync & ~r_start_d;
  assign w_ball_in_p1 = f_in_span(r_ball_y, r_p1_top);
  assign w_ball_in_p2 = f_in_span(r_ball_y, r_p2_top);

  assign w_draw = ((bus.i_Col == C_ZERO)  && f_in_span(bus.i_Row, r_p1_top)) ||
                  ((bus.i_Col == C_X_MAX) && f_in_span(bus.i_Row, r_p2_top)) ||
                  ((bus.i_Col == r_ball_x) && (bus.i_Row == r_ball_y));

  // Next-state and datapath
  always_comb begin
    w_next_state   = r_state;
    w_ball_x_nxt   = r_ball_x;
    w_ball_y_nxt   = r_ball_y;
    w_dx_neg_nxt   = r_dx_neg;
    w_dy_neg_nxt   = r_dy_neg;
    w_p1_score_nxt = r_p1_score;
    w_p2_score_nxt = r_p2_score;
    w_hold_nxt     = r_hold_cnt;
    w_ball_cnt_nxt = '0;

    case (r_state)
      S_IDLE: begin
        w_ball_x_nxt = C_X_MID;
        w_ball_y_nxt = C_Y_MID;
        if (w_start_edge) w_next_state = S_PLAY;
      end

      S_PLAY: begin
        if (w_ball_tick) begin
          // Vertical bounce, independent of the horizontal rule below.
          if (r_ball_y == C_ZERO && r_dy_neg) begin
            w_dy_neg_nxt = 1'b0;
            w_ball_y_nxt = C_ONE;
          end else if (r_ball_y == C_Y_MAX && !r_dy_neg) begin
            w_dy_neg_nxt = 1'b1;
            w_ball_y_nxt = C_Y_BOT;
          end else begin
            w_ball_y_nxt = r_dy_neg ? r_ball_y - C_ONE : r_ball_y + C_ONE;
          end

          // Paddle hit test uses the ball's current row, before the move.
          if (r_ball_x == C_ONE && r_dx_neg) begin
            if (w_ball_in_p1) begin
              w_dx_neg_nxt = 1'b0;
              w_ball_x_nxt = C_TWO;
            end else begin
              w_ball_x_nxt = C_ZERO;
              if (r_p2_score < C_LIMIT) w_p2_score_nxt = r_p2_score + C_SONE;
              w_next_state = S_SCORED;
            end
          end else if (r_ball_x == C_X_RGT && !r_dx_neg) begin
            if (w_ball_in_p2) begin
              w_dx_neg_nxt = 1'b1;
              w_ball_x_nxt = C_X_RGT - C_ONE;
            end else begin
              w_ball_x_nxt = C_X_MAX;
              if (r_p1_score < C_LIMIT) w_p1_score_nxt = r_p1_score + C_SONE;
              w_next_state = S_SCORED;
            end
          end else begin
            w_ball_x_nxt = r_dx_neg ? r_ball_x - C_ONE : r_ball_x + C_ONE;
          end
        end
      end

      S_SCORED: begin
        if (w_ball_tick) begin
          if (r_hold_cnt == C_HOLD_LAST) begin
            if (r_p1_score == C_LIMIT || r_p2_score == C_LIMIT) begin
              w_next_state = S_GAME_OVER;
            end else begin
              // Serve toward the loser: a ball parked at x=0 means P1 lost.
              w_ball_x_nxt = C_X_MID;
              w_ball_y_nxt = C_Y_MID;
              w_dx_neg_nxt = (r_ball_x == C_ZERO);
              w_next_state = S_PLAY;
            end
          end else begin
            w_hold_nxt = r_hold_cnt + C_HONE;
          end
        end
      end

      S_GAME_OVER: begin
        if (w_start_edge) begin
          w_p1_score_nxt = '0;
          w_p2_score_nxt = '0;
          w_ball_x_nxt   = C_X_MID;
          w_ball_y_nxt   = C_Y_MID;
          w_dx_neg_nxt   = 1'b0;
          w_dy_neg_nxt   = 1'b0;
          w_next_state   = S_IDLE;
        end
      end

      default: w_next_state = S_IDLE;
    endcase

    // Ball timing restarts on every state entry so the first move after a
    // serve lands exactly BALL_SPEED cycles later.
    if (w_next_state != r_state) begin
      w_hold_nxt     = '0;
      w_ball_cnt_nxt = '0;
    end else if (!w_ball_tick) begin
      w_ball_cnt_nxt = r_ball_cnt + C_BONE;
    end
  end

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state     <= S_IDLE;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_game_over <= (w_next_state == S_GAME_OVER);
    end
  end

  // Datapath registers
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_ball_x     <= C_X_MID;
      r_ball_y     <= C_Y_MID;
      r_dx_neg     <= 1'b0;
      r_dy_neg     <= 1'b0;
      r_p1_top     <= C_TOP_RST;
      r_p2_top     <= C_TOP_RST;
      r_p1_score   <= '0;
      r_p2_score   <= '0;
      r_ball_cnt   <= '0;
      r_pad_cnt    <= '0;
      r_hold_cnt   <= '0;
      r_start_sync <= 1'b0;
      r_start_d    <= 1'b0;
      r_draw       <= 1'b0;
    end else begin
      r_ball_x     <= w_ball_x_nxt;
      r_ball_y     <= w_ball_y_nxt;
      r_dx_neg     <= w_dx_neg_nxt;
      r_dy_neg     <= w_dy_neg_nxt;
      r_p1_score   <= w_p1_score_nxt;
      r_p2_score   <= w_p2_score_nxt;
      r_ball_cnt   <= w_ball_cnt_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_pad_cnt    <= w_pad_tick ? '0 : r_pad_cnt + C_PONE;
      r_start_sync <= bus.i_Start;
      r_start_d    <= r_start_sync;
      r_draw       <= w_draw;
      if (w_pad_tick && r_state != S_GAME_OVER) begin
        r_p1_top <= f_paddle_next(r_p1_top, bus.i_P1_Up, bus.i_P1_Down);
        r_p2_top <= f_paddle_next(r_p2_top, bus.i_P2_Up, bus.i_P2_Down);
      end
    end
  end

  assign bus.o_Draw      = r_draw;
  assign bus.o_P1_Score  = r_p1_score;
  assign bus.o_P2_Score  = r_p2_score;
  assign bus.o_State     = r_state;
  assign bus.o_Game_Over = r_game_over;

endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed bench for pong_engine on an 8x6 tile field.
// Stimulus pushes expected draw results and expected state-change records into
// queues; two monitors pop and compare whenever the DUT presents a response.
module tb_pong_engine;
  localparam int CW = 6;
  localparam int SW = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pong_if #(.COORD_WIDTH(CW), .SCORE_WIDTH(SW)) bus ();

  pong_engine #(
    .GAME_WIDTH(8), .GAME_HEIGHT(6), .COORD_WIDTH(CW), .PADDLE_HEIGHT(2),
    .BALL_SPEED(4), .PADDLE_SPEED(2), .POINT_HOLD(2),
    .SCORE_WIDTH(SW), .SCORE_LIMIT(2)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_n(rst_n),
    .bus    (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic probe_v = 1'b0;
  logic [12:0] draw_q[$];   // {row, col, expected draw}
  logic [10:0] state_q[$];  // {state, p1, p2, game_over}

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic logic exp_draw(input int row, input int col, input int p1t,
                                    input int p2t, input int bx, input int by);
    exp_draw = (col == 0 && row >= p1t && row <= p1t + 1) ||
               (col == 7 && row >= p2t && row <= p2t + 1) ||
               (col == bx && row == by);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic probe(input int row, input int col, input logic e);
    bus.i_Row = CW'(row);
    bus.i_Col = CW'(col);
    probe_v   = 1'b1;
    draw_q.push_back({CW'(row), CW'(col), e});
    step();
    probe_v = 1'b0;
  endtask

  task automatic push_state(input int st, input int p1, input int p2, input int go);
    state_q.push_back({2'(st), 4'(p1), 4'(p2), 1'(go)});
  endtask

  task automatic wait_state(input int s, input int budget);
    int n;
    n = 0;
    while (int'(bus.o_State) != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_state", int'(bus.o_State), s);
    cyc = 0;
  endtask

  // ---------------- monitors ----------------
  initial begin : draw_monitor
    logic had;
    logic [12:0] e;
    forever begin
      @(posedge clk);
      had = probe_v;
      @(negedge clk);
      if (had) begin
        n_tests++;
        if (draw_q.size() == 0) begin
          n_fail++;
          $display("FAIL draw: response with no expected entry");
        end else begin
          e = draw_q.pop_front();
          if (bus.o_Draw !== e[0]) begin
            n_fail++;
            $display("FAIL draw(row=%0d,col=%0d): o_Draw=%0b, required %0b",
                     e[12:7], e[6:1], bus.o_Draw, e[0]);
          end
        end
      end
    end
  end

  initial begin : state_monitor
    logic [1:0]  prev;
    logic [10:0] act;
    logic [10:0] e;
    prev = 2'd0;
    forever begin
      @(negedge clk);
      if (bus.o_State !== prev) begin
        act = {bus.o_State, bus.o_P1_Score, bus.o_P2_Score, bus.o_Game_Over};
        n_tests++;
        if (state_q.size() == 0) begin
          n_fail++;
          $display("FAIL state_seq: unexpected change to st=%0d p1=%0d p2=%0d go=%0b",
                   act[10:9], act[8:5], act[4:1], act[0]);
        end else begin
          e = state_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL state_seq: got st=%0d p1=%0d p2=%0d go=%0b, required st=%0d p1=%0d p2=%0d go=%0b",
                     act[10:9], act[8:5], act[4:1], act[0], e[10:9], e[8:5], e[4:1], e[0]);
          end
        end
        prev = bus.o_State;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.i_Row = '0; bus.i_Col = '0;
    bus.i_P1_Up = 1'b0; bus.i_P1_Down = 1'b0;
    bus.i_P2_Up = 1'b0; bus.i_P2_Down = 1'b0;
    bus.i_Start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and full draw sweep: paddles at 2, ball at (4,3).
    check("reset_state", int'(bus.o_State), 0);
    check("reset_p1", int'(bus.o_P1_Score), 0);
    check("reset_p2", int'(bus.o_P2_Score), 0);
    check("reset_go", int'(bus.o_Game_Over), 0);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++)
        probe(r, c, exp_draw(r, c, 2, 2, 4, 3));

    // P1 up to the floor; P2 with both buttons stays put.
    bus.i_P1_Up = 1'b1; bus.i_P2_Up = 1'b1; bus.i_P2_Down = 1'b1;
    repeat (20) step();
    bus.i_P1_Up = 1'b0; bus.i_P2_Up = 1'b0; bus.i_P2_Down = 1'b0;
    probe(0, 0, 1'b1);
    probe(2, 0, 1'b0);
    probe(3, 7, 1'b1);
    probe(1, 7, 1'b0);

    // P2 down to its cap (top 4, rows 4-5).
    bus.i_P2_Down = 1'b1;
    repeat (10) step();
    bus.i_P2_Down = 1'b0;
    probe(5, 7, 1'b1);
    probe(3, 7, 1'b0);

    // Expected game sequence up to GAME_OVER.
    push_state(1, 0, 0, 0);
    push_state(2, 1, 0, 0);
    push_state(1, 1, 0, 0);
    push_state(2, 2, 0, 0);
    push_state(3, 2, 0, 1);

    bus.i_Start = 1'b1;
    wait_state(1, 10);
    bus.i_Start = 1'b0;
    // Ball path, tick k lands at cycle 4k: (5,4) (6,5) corner->(5,4) ...
    goto_cyc(9);  probe(5, 6, 1'b1);   // k2 at (6,5)
    probe(4, 5, 1'b0);                  // not yet at (5,4)
    goto_cyc(13); probe(4, 5, 1'b1);   // k3 corner bounce to (5,4)
    bus.i_P2_Up = 1'b1;                 // pull paddle 2 away for a miss
    goto_cyc(29); probe(0, 1, 1'b1);   // k7 at (1,0)
    bus.i_P2_Up = 1'b0;
    goto_cyc(33); probe(1, 2, 1'b1);   // k8 left paddle + top corner -> (2,1)
    goto_cyc(49); probe(5, 6, 1'b1);   // k12 at (6,5), k13 misses
    wait_state(2, 10);

    // SCORED: ball parked at (7,4); move paddle 2 down for the next miss.
    goto_cyc(1); probe(4, 7, 1'b1);
    bus.i_P2_Down = 1'b1;
    wait_state(1, 12);
    goto_cyc(1); probe(3, 4, 1'b1);    // recentred
    goto_cyc(5); probe(2, 5, 1'b1);    // dx=+1 kept dy=-1: (5,2)
    bus.i_P2_Down = 1'b0;
    wait_state(2, 12);
    probe(0, 7, 1'b1);                  // miss position (7,0)
    wait_state(3, 12);

    // GAME_OVER: paddles and ball frozen.
    bus.i_P1_Down = 1'b1; bus.i_P2_Up = 1'b1;
    goto_cyc(10);
    probe(0, 0, 1'b1);
    probe(2, 0, 1'b0);
    probe(5, 7, 1'b1);
    probe(3, 7, 1'b0);
    probe(0, 7, 1'b1);
    bus.i_P1_Down = 1'b0; bus.i_P2_Up = 1'b0;

    // Restart into IDLE; holding i_Start must not re-enter PLAY.
    push_state(0, 0, 0, 0);
    bus.i_Start = 1'b1;
    wait_state(0, 10);
    goto_cyc(20);
    probe(3, 4, 1'b1);
    bus.i_Start = 1'b0;
    repeat (2) step();

    // New game, then asynchronous reset mid-PLAY.
    push_state(1, 0, 0, 0);
    bus.i_Start = 1'b1;
    wait_state(1, 10);
    bus.i_Start = 1'b0;
    bus.i_Row = CW'(0); bus.i_Col = CW'(0);   // paddle 1 tile
    goto_cyc(5);
    check("draw_before_reset", int'(bus.o_Draw), 1);
    push_state(0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_state", int'(bus.o_State), 0);
    check("async_draw", int'(bus.o_Draw), 0);
    check("async_p1", int'(bus.o_P1_Score), 0);
    check("async_p2", int'(bus.o_P2_Score), 0);
    check("async_go", int'(bus.o_Game_Over), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cyc = 0;
    probe(3, 4, 1'b1);                  // ball back at centre
    probe(2, 0, 1'b1);                  // paddle 1 back at top 2
    probe(0, 0, 1'b0);
    repeat (3) step();

    // ---------------- final report ----------------
    check("draw_q_empty", draw_q.size(), 0);
    check("state_q_empty", state_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pong_engine.md
# pong_engine

Parametrised Pong game core with scoring, serve and game-over sequencing. It sits between the four debounced button outputs and the VGA pixel path. It takes tile coordinates (VGA row and column counts divided by 16) and returns a registered draw flag. Beyond paddle and ball motion, it keeps per-player scores up to a configurable limit. It also runs a serve/point/game-over state machine and moves the ball and paddles at independent, configurable rates.

## Interface
- GAME_WIDTH, 40, playfield width in tiles (≥ 6)
- GAME_HEIGHT, 30, playfield height in tiles (≥ PADDLE_HEIGHT+2)
- COORD_WIDTH, 6, bit width of tile coordinates
- PADDLE_HEIGHT, 6, paddle length in tiles
- BALL_SPEED, 1250000, clocks per ball step
- PADDLE_SPEED, 1250000, clocks per paddle step
- POINT_HOLD, 16, ball ticks spent in SCORED before re-serve
- SCORE_WIDTH, 4, score counter width
- SCORE_LIMIT, 9, score that ends the game
- i_Clk  in  1  system clock, all logic on rising edge
- i_Rst_n  in  1  asynchronous active-low reset
- i_Row  in  COORD_WIDTH  current tile row
- i_Col  in  COORD_WIDTH  current tile column
- i_P1_Up, i_P1_Down, i_P2_Up, i_P2_Down  in  1 each  debounced buttons, active high
- i_Start  in  1  start/restart request, rising-edge detected internally
- o_Draw  out  1  tile at (i_Row, i_Col) is paddle or ball
- o_P1_Score, o_P2_Score  out  SCORE_WIDTH  current scores
- o_State  out  2  0=IDLE, 1=PLAY, 2=SCORED, 3=GAME_OVER
- o_Game_Over  out  1  high while in GAME_OVER

## Operation
- Reset values:
  - State IDLE.
  - Scores 0.
  - o_Draw 0, o_Game_Over 0.
  - Ball at (x=GAME_WIDTH/2, y=GAME_HEIGHT/2), dx=+1, dy=+1.
  - Both paddle tops at (GAME_HEIGHT-PADDLE_HEIGHT)/2.
  - Both tick counters 0, start-edge register 0.
- Paddle 1 occupies column 0 and paddle 2 column GAME_WIDTH-1. Each paddle spans rows [top, top+PADDLE_HEIGHT-1].
- Paddle tick: a free-running counter fires when it reaches PADDLE_SPEED-1, then wraps to 0. On a tick, in every state except GAME_OVER:
  - Up only: top decrements, floored at 0.
  - Down only: top increments, capped at GAME_HEIGHT-PADDLE_HEIGHT.
  - Both or neither: no move.
- Ball tick: a counter fires at BALL_SPEED-1. It is cleared to 0 on every state entry.
- IDLE:
  - Ball held at centre.
  - Rising edge of i_Start → PLAY.
- PLAY, on each ball tick:
  - Vertical:
    - y=0 with dy=-1 → dy=+1, y=1.
    - y=GAME_HEIGHT-1 with dy=+1 → dy=-1, y=GAME_HEIGHT-2.
    - Otherwise y+=dy.
  - Horizontal, left side, x=1 with dx=-1:
    - Ball's current y within paddle 1 span → dx=+1, x=2.
    - Otherwise x=0, P2 score +1 → SCORED.
  - Horizontal, right side, x=GAME_WIDTH-2 with dx=+1: mirror of the left side, using paddle 2 and crediting P1.
  - Horizontal, otherwise: x+=dx.
  - Vertical and horizontal rules apply independently in the same tick, so corner hits reflect both.
- SCORED:
  - Ball stays at its miss position.
  - After POINT_HOLD ball ticks:
    - If either score equals SCORE_LIMIT → GAME_OVER.
    - Else the ball recentres and → PLAY.
  - On re-serve, dx points toward the player who lost the point. dy is kept.
- GAME_OVER:
  - Paddles and ball frozen.
  - Rising edge of i_Start → scores cleared, ball recentred, dx=+1, dy=+1 → IDLE. A second i_Start edge is needed to play.
- Score arithmetic:
  - Scores saturate at SCORE_LIMIT and never wrap.
  - SCORE_LIMIT must be < 2^SCORE_WIDTH.
- i_Start edges in PLAY and SCORED are ignored.

## Timing
- o_Draw is registered with 1-cycle latency from i_Row/i_Col. It is computed from the object positions at the sampling edge.
- o_Draw is 1 when any of these holds:
  - i_Col=0 and i_Row is in paddle 1 span.
  - i_Col=GAME_WIDTH-1 and i_Row is in paddle 2 span.
  - (i_Col, i_Row) equals the ball position.
- o_State and o_Game_Over are registered and change on the edge that performs the transition.
- Scores update on the same edge as PLAY→SCORED.
- i_Start edge detect: the edge is recognised in the cycle after i_Start first samples 1. The state changes at the end of that cycle.
- The first ball move after entering PLAY happens exactly BALL_SPEED cycles after entry.
- Asynchronous reset mid-game returns every register to its reset value immediately. Operation resumes on the first clock edge after deassertion.

## Test plan
Benches use GAME_WIDTH=8, GAME_HEIGHT=6, PADDLE_HEIGHT=2, BALL_SPEED=4, PADDLE_SPEED=2, POINT_HOLD=2, SCORE_LIMIT=2.
- Reset, then sweep i_Row/i_Col:
  - o_Draw=1 only at (col0, rows 2–3), (col7, rows 2–3) and ball (4,3).
  - o_State=0, scores 0.
- Hold i_P1_Up 20 cycles → paddle 1 top steps 2→1→0 at one step per 2 cycles, then stays 0. With both P2 buttons held, paddle 2 stays at 2.
- Pulse i_Start, paddles idle:
  - Ball reaches x=6 at y=5 (corner) → dx=-1, dy=-1 on the same tick.
  - A later miss on the right (ball y outside paddle 2) → P1 score 1, o_State=2.
- Continue after the first point:
  - After 2 ball ticks the ball recentres with dx=+1 (toward P2) and o_State=1.
  - A second P2 miss → P1 score 2, then GAME_OVER, o_Game_Over=1.
- In GAME_OVER:
  - Buttons do not move paddles.
  - An i_Start edge clears scores → IDLE.
  - Holding i_Start high does not re-enter PLAY without a new edge.
- Assert i_Rst_n low mid-PLAY for 1 cycle → all outputs return to reset values asynchronously, before the next clock edge.
